// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and helpers for the multi-channel PWM generator:
//               output mode enum, per-channel configuration record and the
//               clock-cycles-per-microsecond helper.
//               Optional macro PWM_PHASE_EN adds a phase field to the record.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Storage width of configuration fields; channels use the low DATA_WIDTH bits,
    // the remainder is always zero and folds away in synthesis.
    localparam int unsigned c_MAX_DW = 64;

    typedef enum logic [0:0] {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef struct packed {
        logic [c_MAX_DW-1:0] period;
        logic [c_MAX_DW-1:0] duty;
        pwm_mode_e           mode;
`ifdef PWM_PHASE_EN
        logic [c_MAX_DW-1:0] phase;
`endif
    } pwm_cfg_t;

    function automatic int unsigned us_cycles(input int unsigned clk_period_ns);
        return 1000 / clk_period_ns;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel
// Description : One PWM channel: pending/active configuration registers,
//               period counter and registered pwm / period_start outputs.
//               Optional macro PWM_PHASE_EN enables a start phase.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_en,
    input  logic     i_wr,
    input  pwm_cfg_t i_cfg,
    output logic     o_pending,
    output logic     o_pwm,
    output logic     o_period_start
);

    pwm_cfg_t              r_pend;
    pwm_cfg_t              r_act;
    logic                  r_pend_valid;
    logic [DATA_WIDTH-1:0] r_k;
    logic                  r_run_d;
    logic                  r_pwm;
    logic                  r_period_start;

    logic                  w_run;
    logic                  w_rise;
    logic                  w_wrap;
    logic                  w_load;
    logic                  w_high;
    logic [c_MAX_DW-1:0]   w_start;
    logic [c_MAX_DW-1:0]   w_k;
    logic [c_MAX_DW-1:0]   w_off;
    logic [c_MAX_DW-1:0]   w_end;
    logic [DATA_WIDTH-1:0] w_k_next;

    // A channel only counts with a non-zero active period; a fresh start
    // (enable rising or period becoming valid) begins at the start value.
    assign w_run  = i_en && (r_act.period != '0);
    assign w_rise = w_run && !r_run_d;

`ifdef PWM_PHASE_EN
    assign w_start = (r_act.phase < r_act.period) ? r_act.phase : '0;
`else
    assign w_start = '0;
`endif

    assign w_k    = w_rise ? w_start : c_MAX_DW'(r_k);
    assign w_wrap = w_run && (w_k == r_act.period - c_MAX_DW'(1));
    // Pending settings take effect at the wrap, or immediately when idle.
    assign w_load = r_pend_valid && (!w_run || w_wrap);

    assign w_k_next = (!w_run || w_wrap) ? '0 : DATA_WIDTH'(w_k + c_MAX_DW'(1));

    // Output level for the current counter value (before registering).
    always_comb begin
        w_off  = (r_act.period - r_act.duty) >> 1;
        w_end  = w_off + r_act.duty;
        w_high = 1'b0;
        if (r_act.duty == '0) begin
            w_high = 1'b0;
        end else if (r_act.duty >= r_act.period) begin
            w_high = 1'b1;
        end else if (r_act.mode == PWM_EDGE) begin
            w_high = (w_k < r_act.duty);
        end else begin
            w_high = (w_k >= w_off) && (w_k < w_end);
        end
    end

    // Counter, configuration registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend         <= '0;
            r_act          <= '0;
            r_pend_valid   <= 1'b0;
            r_k            <= '0;
            r_run_d        <= 1'b0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_k            <= w_k_next;
            r_run_d        <= w_run;
            r_pwm          <= w_run && w_high;
            r_period_start <= w_run && (w_k == '0);
            if (w_load) begin
                r_act        <= r_pend;
                r_pend_valid <= 1'b0;
            end else if (i_wr && !r_pend_valid) begin
                r_pend       <= i_cfg;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign o_pending      = r_pend_valid;
    assign o_pwm          = r_pwm;
    assign o_period_start = r_period_start;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_gen
// Description : NUM_CH independent PWM channels with a shared configuration
//               write port (microsecond units converted to clock cycles).
//               Optional macro PWM_PHASE_EN adds the cfg_phase input.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int CLK_PERIOD = 100,
    localparam int c_CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [c_CH_W-1:0]     cfg_ch,
    input  logic [DATA_WIDTH-1:0] cfg_period,
    input  logic [DATA_WIDTH-1:0] cfg_duty,
    input  logic                  cfg_mode,
`ifdef PWM_PHASE_EN
    input  logic [DATA_WIDTH-1:0] cfg_phase,
`endif
    input  logic [NUM_CH-1:0]     ch_en,
    output logic [NUM_CH-1:0]     pwm,
    output logic [NUM_CH-1:0]     period_start
);

    localparam int unsigned c_US = us_cycles(CLK_PERIOD);

    logic [NUM_CH-1:0]     w_pend;
    logic [DATA_WIDTH-1:0] w_p;
    logic [DATA_WIDTH-1:0] w_d;
    pwm_cfg_t              w_cfg;

    // Microsecond to cycle conversion, truncated to DATA_WIDTH.
    assign w_p = cfg_period * DATA_WIDTH'(c_US);
    assign w_d = cfg_duty * DATA_WIDTH'(c_US);

    // Assemble the configuration record broadcast to all channels.
    always_comb begin
        w_cfg        = '0;
        w_cfg.period = c_MAX_DW'(w_p);
        w_cfg.duty   = c_MAX_DW'(w_d);
        w_cfg.mode   = cfg_mode ? PWM_CENTER : PWM_EDGE;
`ifdef PWM_PHASE_EN
        w_cfg.phase  = c_MAX_DW'(cfg_phase * DATA_WIDTH'(c_US));
`endif
    end

    // A channel is ready when its pending slot is free.
    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == c_CH_W'(i)) begin
                cfg_ready = !w_pend[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            logic w_wr;
            assign w_wr = cfg_valid && cfg_ready && (cfg_ch == c_CH_W'(g));

            pwm_channel #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_ch (
                .clk            (clk),
                .rst            (rst),
                .i_en           (ch_en[g]),
                .i_wr           (w_wr),
                .i_cfg          (w_cfg),
                .o_pending      (w_pend[g]),
                .o_pwm          (pwm[g]),
                .o_period_start (period_start[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multi_gen
// Description : Directed self-checking bench for pwm_multi_gen
//               (CLK_PERIOD=100, 10 cycles per microsecond).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_gen;

    localparam int NUM_CH = 4;
    localparam int DW     = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [DW-1:0] cfg_period;
    logic [DW-1:0] cfg_duty;
    logic          cfg_mode;
`ifdef PWM_PHASE_EN
    logic [DW-1:0] cfg_phase;
`endif
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] pwm;
    logic [NUM_CH-1:0] period_start;

    int checks = 0;
    int errors = 0;

    pwm_multi_gen #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .CLK_PERIOD (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .cfg_mode     (cfg_mode),
`ifdef PWM_PHASE_EN
        .cfg_phase    (cfg_phase),
`endif
        .ch_en        (ch_en),
        .pwm          (pwm),
        .period_start (period_start)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input int per, input int duty, input logic mode,
                             input string tag);
        @(negedge clk);
        cfg_ch     = 2'(ch);
        cfg_period = per;
        cfg_duty   = duty;
        cfg_mode   = mode;
        cfg_valid  = 1'b1;
        #1;
        check(tag, cfg_ready, 1);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic wait_ps(input int ch, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (period_start[ch]) found = 1'b1;
        end
        check(tag, found, 1);
    endtask

    // 40 samples of pwm[ch], starting with the current sample.
    task automatic capture(input int ch, output logic [63:0] pat);
        pat    = '0;
        pat[0] = pwm[ch];
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            pat[i] = pwm[ch];
        end
    endtask

    task automatic count_win(input int ch, input int n, output int hi, output int ps);
        hi = 0;
        ps = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pwm[ch])          hi++;
            if (period_start[ch]) ps++;
        end
    endtask

    initial begin
        logic [63:0] pat;
        int hi, ps;

        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_duty   = '0;
        cfg_mode   = 1'b0;
`ifdef PWM_PHASE_EN
        cfg_phase  = '0;
`endif
        ch_en      = '0;

        // Reset state
        #20;
        check("rst_pwm", pwm, 0);
        check("rst_ps", period_start, 0);
        check("rst_ready", cfg_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // ch0 edge 4us/1us, ch1 center 4us/2us
        cfg_write(0, 4, 1, 1'b0, "w0_ready");
        cfg_write(1, 4, 2, 1'b1, "w1_ready");
        @(negedge clk);
        ch_en = 4'b0011;

        wait_ps(0, "ch0_ps_timeout");
        capture(0, pat);
        check("ch0_edge_pattern", pat, 64'h3FF);
        @(negedge clk);
        check("ch0_period_40", period_start[0], 1);

        wait_ps(1, "ch1_ps_timeout");
        capture(1, pat);
        check("ch1_center_pattern", pat, 64'h3FFFFC00);

        // Mid-period duty change on ch0, blocked second write, ch2 write accepted
        wait_ps(0, "ch0_ps2_timeout");
        pat    = '0;
        pat[0] = pwm[0];
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            pat[i] = pwm[0];
            if (i == 4) begin
                cfg_ch = 2'd0; cfg_period = 4; cfg_duty = 3; cfg_mode = 1'b0; cfg_valid = 1'b1;
                #1 check("ch0_mid_ready", cfg_ready, 1);
            end else if (i == 5) begin
                cfg_duty = 2;
                check("ch0_second_blocked", cfg_ready, 0);
            end else if (i == 6) begin
                cfg_ch = 2'd2; cfg_duty = 2;
                #1 check("ch2_ready_meanwhile", cfg_ready, 1);
            end else if (i == 7) begin
                cfg_valid = 1'b0;
                check("ch2_accepted", cfg_ready, 0);
            end else if (i == 8) begin
                check("ch2_loaded_idle", cfg_ready, 1);
                cfg_ch = 2'd0;
            end else if (i == 20) begin
                check("ch0_pending_hold", cfg_ready, 0);
            end
        end
        check("ch0_old_period", pat, 64'h3FF);
        @(negedge clk);
        check("ch0_wrap_ps", period_start[0], 1);
        check("ch0_ready_after_wrap", cfg_ready, 1);
        capture(0, pat);
        check("ch0_new_period", pat, 64'h3FFFFFFF);

        // Boundaries: duty=0 and duty>period
        cfg_write(3, 4, 0, 1'b0, "w3_ready");
        cfg_write(2, 4, 5, 1'b0, "w2_ready");
        @(negedge clk);
        ch_en = 4'b1111;
        count_win(3, 80, hi, ps);
        check("ch3_duty0_high", hi, 0);
        check("ch3_duty0_ps", ps, 2);
        wait_ps(2, "ch2_ps_timeout");
        capture(2, pat);
        check("ch2_full_duty", pat, 64'hFF_FFFF_FFFF);

        // Period 0 on running ch2 applies at the next wrap
        cfg_write(2, 0, 2, 1'b0, "w2p0_ready");
        count_win(2, 45, hi, ps);
        count_win(2, 80, hi, ps);
        check("ch2_p0_high", hi, 0);
        check("ch2_p0_ps", ps, 0);

        // Enable falling mid-high, then rising
        wait_ps(0, "ch0_ps3_timeout");
        ch_en[0] = 1'b0;
        @(negedge clk);
        check("ch0_fall_low", pwm[0], 0);
        count_win(0, 50, hi, ps);
        check("ch0_off_high", hi, 0);
        check("ch0_off_ps", ps, 0);
        ch_en[0] = 1'b1;
        @(negedge clk);
        check("ch0_rise_ps", period_start[0], 1);
        capture(0, pat);
        check("ch0_restart_pattern", pat, 64'h3FFFFFFF);

        // Asynchronous reset 15 clocks into a period
        for (int i = 0; i < 16; i++) @(negedge clk);
        check("ch0_high_before_rst", pwm[0], 1);
        #10 rst = 1'b1;
        #1;
        check("arst_pwm", pwm, 0);
        check("arst_ps", period_start, 0);
        check("arst_ready", cfg_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        count_win(0, 100, hi, ps);
        check("post_rst_ch0_high", hi, 0);
        check("post_rst_ch0_ps", ps, 0);
        count_win(1, 50, hi, ps);
        check("post_rst_ch1_high", hi, 0);

        // Reconfigure after reset
        cfg_write(0, 4, 1, 1'b0, "w0_again_ready");
        wait_ps(0, "ch0_ps4_timeout");
        capture(0, pat);
        check("ch0_reconfig_pattern", pat, 64'h3FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_multi_gen.md
PWM_MULTI_GEN -- requirements
Module: pwm_multi_gen

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent PWM channels.
REQ-002 Parameter DATA_WIDTH, default 32, width of period/duty/counter values.
REQ-003 Parameter CLK_PERIOD, default 100, clock period in ns; US_CYCLES = 1000/CLK_PERIOD clock cycles per µs.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 cfg_valid  input  1  configuration write request.
REQ-007 cfg_ready  output  1  configuration write accepted when high together with cfg_valid.
REQ-008 cfg_ch  input  $clog2(NUM_CH), minimum 1  target channel of the write.
REQ-009 cfg_period  input  DATA_WIDTH  period in µs.
REQ-010 cfg_duty  input  DATA_WIDTH  high time in µs.
REQ-011 cfg_mode  input  1  0 = edge-aligned, 1 = center-aligned.
REQ-012 ch_en  input  NUM_CH  per-channel run enable.
REQ-013 pwm  output  NUM_CH  PWM outputs, registered.
REQ-014 period_start  output  NUM_CH  one-cycle pulse, registered, in the cycle pwm reflects counter value 0.

Function
REQ-015 Conversion: P = cfg_period*US_CYCLES and D = cfg_duty*US_CYCLES, each truncated to DATA_WIDTH bits, computed at write acceptance.
REQ-016 Handshake: cfg_ready = NOT pending[cfg_ch]; on cfg_valid&&cfg_ready, P/D/mode go to that channel's pending register and pending is set.
REQ-017 Pending apply: while the channel runs, pending loads into active registers in the cycle the counter wraps to 0; while ch_en=0, it loads on the next clock; pending clears on load.
REQ-018 Counter k per channel: runs 0..P-1 while ch_en=1 and P>0, then wraps to 0; held at 0 when ch_en=0 or P=0.
REQ-019 Edge mode: pwm is set high in the cycle after k<D, otherwise low.
REQ-020 Center mode: with O=(P-D)>>1, pwm is set high in the cycle after O<=k<O+D, otherwise low.
REQ-021 Latency: pwm and period_start lag k by exactly one clock.
REQ-022 Boundaries: D=0 gives constant low; D>=P with P>0 gives constant high; P=0 gives pwm low and no period_start.
REQ-023 ch_en falling: k returns to 0 and pwm is low on the next clock, with no partial-period completion.
REQ-024 ch_en rising: the counter starts at 0 (or at the phase, REQ-030); the first period_start is asserted one clock after k=0 is reached.
REQ-025 Simultaneous write and wrap on the same channel: the write is held in pending and applies at the next wrap; the current wrap uses the previously pending values.
REQ-026 Channels are fully independent; a write to one channel never disturbs another.

Reset
REQ-027 On rst: all k=0; pwm=0; period_start=0; active and pending P/D/mode=0; pending flags=0; cfg_ready=1.
REQ-028 rst asserted mid-period: outputs go to reset values immediately (asynchronously); after release, channels stay idle until a configuration is written.

Configuration
REQ-029 Macro PWM_PHASE_EN compiles in input cfg_phase (DATA_WIDTH, µs), converted as in REQ-015 and stored with pending/active.
REQ-030 With PWM_PHASE_EN: on ch_en rising, k starts at phase, or at 0 if phase>=P. Without it: the port is absent and k starts at 0.

Structure
REQ-031 Package pwm_pkg holds the pwm_mode_e typedef (PWM_EDGE, PWM_CENTER), the channel config struct (period, duty, mode[, phase]) and the US_CYCLES helper function.
REQ-032 Sub-module pwm_channel implements counter, pending/active registers and output for one channel; the top level instantiates NUM_CH copies plus the cfg decode.

Verification (CLK_PERIOD=100, US_CYCLES=10)
REQ-033 ch0 edge, period=4, duty=1, ch_en[0]=1 -> pwm[0] high 10 clocks, low 30 clocks, period_start[0] every 40 clocks.
REQ-034 ch1 center, period=4, duty=2 -> pwm[1] low 10, high 20, low 10 per 40-clock period.
REQ-035 Mid-period write of duty=3 to the running ch0 -> current period keeps 10-clock high; next period is 30 high / 10 low; cfg_ready for ch0 is low until the wrap.
REQ-036 Second write to ch0 while pending -> cfg_ready=0 and the write is not accepted until the wrap; writes to ch2 are accepted meanwhile.
REQ-037 duty=0 gives pwm constantly 0; duty=5 with period=4 gives constantly 1; period=0 gives pwm 0 and no period_start.
REQ-038 rst pulsed at clock 15 of a period -> pwm=0 and cfg_ready=1 immediately; outputs stay 0 after release until reconfigured.
